// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, slice geometry
// and the all-dark segment pattern (segments a..g, active-low, a is bit 0).
package sseg_pkg;

    localparam int SLICE_BITS = 4;
    localparam logic [SLICE_BITS-1:0] GUARD_SLICE = 4'd0;
    localparam logic [0:6] SEG_OFF = 7'b1111111;

    localparam logic [0:6] GLYPHS [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [0:6] seg
);

    always_comb begin
        seg = GLYPHS[hex];
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scanner with PWM dimming, guard slice, blinking and
// frame-synchronous shadowing of the display inputs.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_LOG2   = 16,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [3:0]              brightness,
    output logic [0:6]              sseg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_DIGITS - 1);

    logic [1:0]            rst_sync;
    logic                  rst_n_int;
    logic [DIV_LOG2-1:0]   pcnt;
    logic [IDXW-1:0]       idx;
    logic [BLINK_LOG2-1:0] bcnt;
    logic                  blink_off;
    logic                  first;
    logic [3:0]            sh_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sh_dp;
    logic [NUM_DIGITS-1:0] sh_blank;
    logic [NUM_DIGITS-1:0] sh_blink;
    logic                  slot_end;
    logic                  wrap;
    logic                  capture;
    logic [SLICE_BITS-1:0] slice;
    logic                  visible;
    logic [0:6]            glyph;
    logic [NUM_DIGITS-1:0] an_next;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];
    assign slot_end  = &pcnt;
    assign wrap      = slot_end && (idx == LAST_IDX);
    assign capture   = wrap || first;
    assign slice     = pcnt[DIV_LOG2-1 -: SLICE_BITS];

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            pcnt      <= '0;
            idx       <= '0;
            bcnt      <= '0;
            blink_off <= 1'b0;
            first     <= 1'b1;
        end else begin
            pcnt  <= pcnt + DIV_LOG2'(1);
            first <= 1'b0;
            if (slot_end) begin
                idx <= wrap ? '0 : idx + IDXW'(1);
            end
            if (wrap) begin
                bcnt <= bcnt + BLINK_LOG2'(1);
                if (&bcnt) begin
                    blink_off <= ~blink_off;
                end
            end
        end
    end

    // Shadows only change at a frame boundary so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                sh_digit[k] <= '0;
            end
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_blink <= '0;
        end else if (capture) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                sh_digit[k] <= digits[4*k +: 4];
            end
            sh_dp    <= dp_in;
            sh_blank <= blank_mask;
            sh_blink <= blink_mask;
        end
    end

    hex_to_sseg u_decode (
        .hex (sh_digit[idx]),
        .seg (glyph)
    );

    assign visible = (slice != GUARD_SLICE) && (slice <= brightness) &&
                     !sh_blank[idx] && !(sh_blink[idx] && blink_off);

    always_comb begin
        an_next = '1;
        if (visible) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            an         <= '1;
            sseg       <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            sseg       <= glyph;
            dp         <= ~sh_dp[idx];
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: cycle-number arithmetic model checked every cycle,
// plus directed literal and per-frame duty checks.
module tb_sseg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BL    = 1;
    localparam int SLOT  = 1 << DIV;
    localparam int FRAME = N * SLOT;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  digits;
    logic [3:0]   dp_in, blank_mask, blink_mask, brightness;
    logic [0:6]   sseg;
    logic         dp;
    logic [3:0]   an;
    logic         frame_tick;

    int vectors = 0;
    int miscompares = 0;

    sseg_scan_driver #(.NUM_DIGITS(N), .DIV_LOG2(DIV), .BLINK_LOG2(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .sseg       (sseg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    logic [0:6] ref_glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model: e counts active edges since the synchronised release; the outputs
    // after edge e describe scan cycle e-1 of the frame sequence.
    int         rel = 0;
    int         e = 0;
    int         mc, ms, md, mf;
    bit         mvis, mboff;
    logic [3:0] m_digit [N];
    logic [N-1:0] m_dp = '0, m_blank = '0, m_blink = '0;
    logic [3:0] exp_an = 4'b1111;
    logic [0:6] exp_sseg = 7'b1111111;
    logic       exp_dp = 1'b1;
    logic       exp_ft = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rel = 0;
            e = 0;
            for (int k = 0; k < N; k++) m_digit[k] = 4'd0;
            m_dp = '0; m_blank = '0; m_blink = '0;
            exp_an = 4'b1111; exp_sseg = 7'b1111111; exp_dp = 1'b1; exp_ft = 1'b0;
        end else begin
            rel++;
            if (rel >= 3) begin
                e++;
                mc = e - 1;
                ms = (mc % SLOT) / (SLOT / 16);
                md = (mc / SLOT) % N;
                mf = mc / FRAME;
                mboff = ((mf >> BL) % 2) == 1;
                mvis = (ms != 0) && (ms <= int'(brightness)) && !m_blank[md] &&
                       !(m_blink[md] && mboff);
                exp_an = 4'b1111;
                if (mvis) exp_an[md] = 1'b0;
                exp_sseg = ref_glyph[m_digit[md]];
                exp_dp   = !m_dp[md];
                exp_ft   = (e % FRAME) == 0;
                if (e == 1 || (e % FRAME) == 0) begin
                    for (int k = 0; k < N; k++) m_digit[k] = digits[4*k +: 4];
                    m_dp = dp_in; m_blank = blank_mask; m_blink = blink_mask;
                end
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (an !== exp_an || sseg !== exp_sseg || dp !== exp_dp || frame_tick !== exp_ft) begin
            miscompares++;
            $display("[TB] FAIL cycle e=%0d: an=%b sseg=%b dp=%b tick=%b, model an=%b sseg=%b dp=%b tick=%b",
                     e, an, sseg, dp, frame_tick, exp_an, exp_sseg, exp_dp, exp_ft);
        end
    end

    task automatic applyStimulus(input logic [15:0] dg, input logic [3:0] dpv,
                                 input logic [3:0] blank, input logic [3:0] blink,
                                 input logic [3:0] br);
        digits = dg; dp_in = dpv; blank_mask = blank; blink_mask = blink; brightness = br;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ea, input logic [0:6] es,
                               input logic ed, input logic et);
        vectors++;
        if (an !== ea || sseg !== es || dp !== ed || frame_tick !== et) begin
            miscompares++;
            $display("[TB] FAIL %s: an=%b sseg=%b dp=%b tick=%b, want an=%b sseg=%b dp=%b tick=%b",
                     name, an, sseg, dp, frame_tick, ea, es, ed, et);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic waitActive(input int target);
        int guard = 0;
        while (e != target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (e != target) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wait_e: got %0d, want %0d", e, target);
        end
    endtask

    int lowCnt [N];
    int dpLow, tickCnt;

    task automatic measureFrame(input int f);
        waitActive(FRAME * f);
        for (int k = 0; k < N; k++) lowCnt[k] = 0;
        dpLow = 0;
        tickCnt = 0;
        repeat (FRAME) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (!an[k]) lowCnt[k]++;
            if (!dp) dpLow++;
            if (frame_tick) tickCnt++;
        end
    endtask

    task automatic checkFrame(input string name, input int l0, input int l1, input int l2,
                              input int l3, input int dpl);
        checkCount({name, "_d0"}, lowCnt[0], l0);
        checkCount({name, "_d1"}, lowCnt[1], l1);
        checkCount({name, "_d2"}, lowCnt[2], l2);
        checkCount({name, "_d3"}, lowCnt[3], l3);
        checkCount({name, "_dp"}, dpLow, dpl);
        checkCount({name, "_tick"}, tickCnt, 1);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("reset_hold", 4'b1111, 7'b1111111, 1'b1, 1'b0);

        // Scan with full brightness
        applyStimulus(16'h3210, 4'b0000, 4'b0000, 4'b0000, 4'd15);
        rst = 1'b1;
        waitActive(1);  checkOutput("scan_e1",  4'b1111, 7'b0000001, 1'b1, 1'b0);
        waitActive(2);  checkOutput("scan_e2",  4'b1110, 7'b0000001, 1'b1, 1'b0);
        waitActive(17); checkOutput("scan_e17", 4'b1111, 7'b1001111, 1'b1, 1'b0);
        waitActive(18); checkOutput("scan_e18", 4'b1101, 7'b1001111, 1'b1, 1'b0);
        waitActive(34); checkOutput("scan_e34", 4'b1011, 7'b0010010, 1'b1, 1'b0);
        waitActive(63); checkOutput("scan_e63", 4'b0111, 7'b0000110, 1'b1, 1'b0);
        waitActive(64); checkOutput("first_tick", 4'b0111, 7'b0000110, 1'b1, 1'b1);
        waitActive(65); checkOutput("scan_e65", 4'b1111, 7'b0000001, 1'b1, 1'b0);

        measureFrame(2);
        checkFrame("bright15", 15, 15, 15, 15, 0);
        applyStimulus(16'h3210, 4'b0000, 4'b0000, 4'b0000, 4'd0);
        measureFrame(3);
        checkFrame("bright0", 0, 0, 0, 0, 0);
        applyStimulus(16'h3210, 4'b1000, 4'b0100, 4'b0001, 4'd4);
        measureFrame(4);
        checkFrame("bright4", 4, 4, 4, 4, 0);

        // Masks captured at the frame 5 boundary
        applyStimulus(16'h3210, 4'b1000, 4'b0100, 4'b0001, 4'd15);
        measureFrame(5);
        checkFrame("blink_on", 15, 15, 0, 15, 16);
        measureFrame(6);
        checkFrame("blink_off", 0, 15, 0, 15, 16);
        measureFrame(8);
        checkFrame("blink_on2", 15, 15, 0, 15, 16);

        // Mid-frame input change must wait for the next frame
        applyStimulus(16'h1111, 4'b0000, 4'b0000, 4'b0000, 4'd15);
        waitActive(642); checkOutput("cap_ones_d0", 4'b1110, 7'b1001111, 1'b1, 1'b0);
        waitActive(658);
        applyStimulus(16'h2222, 4'b0000, 4'b0000, 4'b0000, 4'd15);
        waitActive(690); checkOutput("cap_hold_d3", 4'b0111, 7'b1001111, 1'b1, 1'b0);
        waitActive(706); checkOutput("cap_twos_d0", 4'b1110, 7'b0010010, 1'b1, 1'b0);

        // Asynchronous reset in slot 2
        waitActive(740);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 checkOutput("reset_async", 4'b1111, 7'b1111111, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        waitActive(1);  checkOutput("restart_e1",  4'b1111, 7'b0000001, 1'b1, 1'b0);
        waitActive(2);  checkOutput("restart_e2",  4'b1110, 7'b0010010, 1'b1, 1'b0);
        waitActive(18); checkOutput("restart_e18", 4'b1101, 7'b0010010, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
